// File: rtl/lgn_img_pkg.sv
// Shared constants and types for the LGN byte-serial image receiver.
package lgn_img_pkg;

    localparam int BYTES_PER_IMAGE = 32;
    localparam int BYTE_W          = 8;
    localparam int IMG_W           = BYTES_PER_IMAGE * BYTE_W;
    localparam int IDX_W           = $clog2(BYTES_PER_IMAGE);
    localparam int FCNT_W          = 16;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_IMAGE - 1);

    typedef logic [IMG_W-1:0]  img_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

endpackage

// File: rtl/lgn_img_slot.sv
// Valid/ready holding register for completed images, with drop detection and a delivery counter.
module lgn_img_slot
    import lgn_img_pkg::*;
#(
    parameter int CNT_W = FCNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done,
    input  img_t             frame,
    input  logic             img_ready,
    output img_t             img_data,
    output logic             img_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_count
);

    slot_state_t state, state_next;
    logic        load;
    logic        drop;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (frame_done) begin
                    state_next = SLOT_FULL;
                    load       = 1'b1;
                end
            end
            SLOT_FULL: begin
                // A consume in the same cycle as a new frame refills the slot without a bubble.
                if (frame_done) begin
                    load = img_ready;
                    drop = !img_ready;
                end else if (img_ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SLOT_EMPTY;
            img_data    <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                img_data    <= frame;
                frame_count <= frame_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign img_valid = (state == SLOT_FULL);

endmodule

// File: rtl/lgn_image_rx.sv
// Byte-serial image receiver: assembles pixel bytes into 256-bit frames and hands them to the slot.
module lgn_image_rx
    import lgn_img_pkg::*;
#(
    parameter int FCNT_W = lgn_img_pkg::FCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_en,
    input  logic              frame_sync,
    output logic [IMG_W-1:0]  img_data,
    output logic              img_valid,
    input  logic              img_ready,
    output logic [IDX_W-1:0]  byte_index,
    output logic              overflow,
    output logic [FCNT_W-1:0] frame_count
);

    img_t buffer;
    idx_t eff_idx;
    img_t frame_word;
    logic frame_done;

    assign eff_idx    = frame_sync ? '0 : byte_index;
    assign frame_done = in_en && (eff_idx == LAST_IDX);

    // The final byte is merged here so the slot sees the whole frame in the same cycle.
    always_comb begin
        frame_word = buffer;
        frame_word[eff_idx*BYTE_W +: BYTE_W] = in_byte;
    end

    // NOTE: the assembly buffer is reset because a reset must leave no stale pixels visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer     <= '0;
            byte_index <= '0;
        end else if (in_en) begin
            buffer     <= frame_word;
            byte_index <= (eff_idx == LAST_IDX) ? '0 : eff_idx + 1'b1;
        end else if (frame_sync) begin
            byte_index <= '0;
        end
    end

    lgn_img_slot #(
        .CNT_W (FCNT_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .frame       (frame_word),
        .img_ready   (img_ready),
        .img_data    (img_data),
        .img_valid   (img_valid),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

endmodule

// File: tb/tb_lgn_image_rx.sv
// Scoreboard bench for lgn_image_rx: directed frames, expected images queued, a monitor compares deliveries.
module tb_lgn_image_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_en;
    logic         frame_sync;
    logic [255:0] img_data;
    logic         img_valid;
    logic         img_ready;
    logic [4:0]   byte_index;
    logic         overflow;
    logic [15:0]  frame_count;

    typedef struct {
        logic [255:0] img;
        logic [15:0]  fc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    lgn_image_rx dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_en       (in_en),
        .frame_sync  (frame_sync),
        .img_data    (img_data),
        .img_valid   (img_valid),
        .img_ready   (img_ready),
        .byte_index  (byte_index),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A new image is presented when valid rises or a handshake preceded a still-valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (img_valid && (!prev_valid || prev_hs)) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_image: got %h with no expected image queued", img_data);
                end else begin
                    e = sb.pop_front();
                    check("img_data", img_data, e.img);
                    check("frame_count_at_delivery", 256'(frame_count), 256'(e.fc));
                end
            end
            prev_valid = img_valid;
            prev_hs    = img_valid && img_ready;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sync);
        in_byte    = b;
        in_en      = 1'b1;
        frame_sync = sync;
        @(posedge clk);
        #1;
        in_en      = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_img_valid", 256'(img_valid), 256'(0));
        check("rst_img_data", img_data, 256'(0));
        check("rst_byte_index", 256'(byte_index), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));
        check("rst_frame_count", 256'(frame_count), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [255:0] fill(input logic [7:0] b);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = b;
        return v;
    endfunction

    task automatic push(input logic [255:0] img, input logic [15:0] fc);
        exp_t e;
        e.img = img;
        e.fc  = fc;
        sb.push_back(e);
    endtask

    // Sends a uniform frame and queues it as expected unless it is meant to be dropped.
    task automatic send_fill(input logic [7:0] b, input bit expect_it, input logic [15:0] fc);
        for (int k = 0; k < 32; k++) begin
            if (k == 31 && expect_it) push(fill(b), fc);
            send_byte(b, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] img;
        rst        = 1'b1;
        in_byte    = '0;
        in_en      = 1'b0;
        frame_sync = 1'b0;
        img_ready  = 1'b0;
        #1;

        // Test 1: incrementing frame, consumer not ready.
        do_reset();
        for (int k = 0; k < 32; k++) img[8*k +: 8] = 8'(k);
        push(img, 16'd1);
        for (int k = 0; k < 32; k++) send_byte(8'(k), 1'b0);
        check("t1_valid", 256'(img_valid), 256'(1));
        check("t1_byte0", 256'(img_data[7:0]), 256'(8'h00));
        check("t1_byte31", 256'(img_data[255:248]), 256'(8'h1F));
        check("t1_fc", 256'(frame_count), 256'(1));

        // Test 2: frame arriving into a full, stalled slot is dropped.
        send_fill(8'hAA, 1'b0, 16'd0);
        check("t2_overflow", 256'(overflow), 256'(1));
        check("t2_data_held", img_data, img);
        check("t2_fc", 256'(frame_count), 256'(1));
        check("t2_valid_held", 256'(img_valid), 256'(1));
        img_ready = 1'b1;
        idle(1);
        check("t2_valid_drop", 256'(img_valid), 256'(0));
        img_ready = 1'b0;

        // Test 3: consumer always ready, two frames back to back.
        do_reset();
        img_ready = 1'b1;
        send_fill(8'h55, 1'b1, 16'd1);
        send_fill(8'hC3, 1'b1, 16'd2);
        check("t3_valid", 256'(img_valid), 256'(1));
        check("t3_data", img_data, fill(8'hC3));
        check("t3_overflow", 256'(overflow), 256'(0));
        check("t3_fc", 256'(frame_count), 256'(2));
        idle(1);
        check("t3_drained", 256'(img_valid), 256'(0));

        // Test 3b: consume and refill in the same cycle.
        img_ready = 1'b0;
        send_fill(8'h12, 1'b1, 16'd3);
        for (int k = 0; k < 31; k++) send_byte(8'h34, 1'b0);
        img_ready = 1'b1;
        push(fill(8'h34), 16'd4);
        send_byte(8'h34, 1'b0);
        img_ready = 1'b0;
        check("t3b_valid", 256'(img_valid), 256'(1));
        check("t3b_data", img_data, fill(8'h34));
        check("t3b_overflow", 256'(overflow), 256'(0));
        check("t3b_fc", 256'(frame_count), 256'(4));
        img_ready = 1'b1;
        idle(1);
        check("t3b_drained", 256'(img_valid), 256'(0));

        // Test 4: realignment with and without an accompanying byte.
        for (int k = 0; k < 5; k++) send_byte(8'h99, 1'b0);
        check("t4_idx5", 256'(byte_index), 256'(5));
        frame_sync = 1'b1;
        idle(1);
        frame_sync = 1'b0;
        check("t4_sync_noen", 256'(byte_index), 256'(0));
        for (int k = 0; k < 10; k++) send_byte(8'h99, 1'b0);
        check("t4_idx10", 256'(byte_index), 256'(10));
        send_byte(8'h77, 1'b1);
        check("t4_idx_after_sync", 256'(byte_index), 256'(1));
        img = fill(8'h11);
        img[7:0] = 8'h77;
        for (int k = 0; k < 31; k++) begin
            if (k == 30) push(img, 16'd5);
            send_byte(8'h11, 1'b0);
        end
        check("t4_idx_wrap", 256'(byte_index), 256'(0));
        check("t4_fc", 256'(frame_count), 256'(5));
        idle(1);

        // Test 5: in_en gaps between every byte.
        for (int k = 0; k < 32; k++) img[8*k +: 8] = 8'(k * 7 + 3);
        for (int k = 0; k < 32; k++) begin
            if (k == 31) push(img, 16'd6);
            send_byte(8'(k * 7 + 3), 1'b0);
            idle(1);
        end
        check("t5_fc", 256'(frame_count), 256'(6));
        idle(3);
        check("t5_fc_once", 256'(frame_count), 256'(6));

        // Test 6: reset mid-frame discards the partial frame.
        img_ready = 1'b0;
        for (int k = 0; k < 20; k++) send_byte(8'h5A, 1'b0);
        check("t6_idx20", 256'(byte_index), 256'(20));
        do_reset();
        send_fill(8'hFF, 1'b1, 16'd1);
        check("t6_valid", 256'(img_valid), 256'(1));
        check("t6_data", img_data, {256{1'b1}});
        check("t6_fc", 256'(frame_count), 256'(1));
        idle(3);

        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
